regfile_write_scheduler: RTL

Shares the single write port of the KGP-RISC 32×32 register file between three write-back requesters: ALU result, load data and link address. It also keeps a 32-entry busy scoreboard so the decode stage can stall on operands whose write is still outstanding. It sits between the execute/memory stages and the register file write port, and drives that port's write enable, address and data from registers.

---
 rtl/regfile_write_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Round-robin sharing of the register-file write port between ALU, load and link
// write-back, plus a busy scoreboard that decode uses to stall on pending writes.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              reqValid,
  input  logic [ADDR_WIDTH-1:0]   reqAddr0,
  input  logic [ADDR_WIDTH-1:0]   reqAddr1,
  input  logic [ADDR_WIDTH-1:0]   reqAddr2,
  input  logic [DATA_WIDTH-1:0]   reqData0,
  input  logic [DATA_WIDTH-1:0]   reqData1,
  input  logic [DATA_WIDTH-1:0]   reqData2,
  output logic [2:0]              reqGrant,
  output logic                    wrEn,
  output logic [ADDR_WIDTH-1:0]   wrAddr,
  output logic [DATA_WIDTH-1:0]   wrData,
  input  logic                    resvEn,
  input  logic [ADDR_WIDTH-1:0]   resvAddr,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   rs1Addr,
  input  logic [ADDR_WIDTH-1:0]   rs2Addr,
  output logic                    rs1Busy,
  output logic                    rs2Busy,
  output logic [2**ADDR_WIDTH-1:0] busyMask
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [1:0]            ptr_p0;
  logic [1:0]            ptr_nxt_p0;
  logic [2:0]            grant_p0;
  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [DEPTH-1:0]      busy_p1;
  logic [DEPTH-1:0]      busy_nxt_p1;

  // Stage 0: combinational round-robin arbitration starting at ptr_p0
  always_comb begin
    grant_p0 = 3'b000;
    case (ptr_p0)
      2'd0: begin
        if      (reqValid[0]) grant_p0 = 3'b001;
        else if (reqValid[1]) grant_p0 = 3'b010;
        else if (reqValid[2]) grant_p0 = 3'b100;
      end
      2'd1: begin
        if      (reqValid[1]) grant_p0 = 3'b010;
        else if (reqValid[2]) grant_p0 = 3'b100;
        else if (reqValid[0]) grant_p0 = 3'b001;
      end
      default: begin
        if      (reqValid[2]) grant_p0 = 3'b100;
        else if (reqValid[0]) grant_p0 = 3'b001;
        else if (reqValid[1]) grant_p0 = 3'b010;
      end
    endcase
  end

  assign reqGrant = grant_p0;
  assign vld_p0   = |(reqValid & grant_p0);

  always_comb begin
    addr_p0    = '0;
    data_p0    = '0;
    ptr_nxt_p0 = ptr_p0;
    if (grant_p0[0]) begin
      addr_p0    = reqAddr0;
      data_p0    = reqData0;
      ptr_nxt_p0 = 2'd1;
    end else if (grant_p0[1]) begin
      addr_p0    = reqAddr1;
      data_p0    = reqData1;
      ptr_nxt_p0 = 2'd2;
    end else if (grant_p0[2]) begin
      addr_p0    = reqAddr2;
      data_p0    = reqData2;
      ptr_nxt_p0 = 2'd0;
    end
  end

  // Stage 1: registered write port; address/data hold while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p0 <= 2'd0;
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else if (vld_p0) begin
      ptr_p0 <= ptr_nxt_p0;
      wrEn   <= 1'b1;
      wrAddr <= addr_p0;
      wrData <= data_p0;
    end else begin
      wrEn   <= 1'b0;
    end
  end

  // Scoreboard: clear on completed write, reservation overrides, flush overrides all
  always_comb begin
    busy_nxt_p1 = busy_p1;
    if (wrEn)   busy_nxt_p1[wrAddr]   = 1'b0;
    if (resvEn) busy_nxt_p1[resvAddr] = 1'b1;
    if (flush)  busy_nxt_p1           = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_p1 <= '0;
    else     busy_p1 <= busy_nxt_p1;
  end

  assign rs1Busy  = busy_p1[rs1Addr];
  assign rs2Busy  = busy_p1[rs2Addr];
  assign busyMask = busy_p1;

endmodule
